// File: rtl/interrupt_controller_8_if.sv
// Request/dispatch bus for interrupt_controller_8. The producer/consumer side drives
// the raw lines, mask and ack. The controller drives the presented ID and the pending view.
interface interrupt_controller_8_if;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  modport master (output irq_in, mask, irq_ack, input irq_valid, irq_id, pending);
  modport slave  (input irq_in, mask, irq_ack, output irq_valid, irq_id, pending);
endinterface

// File: rtl/interrupt_controller_8.sv
// 8-line interrupt capture with per-line mask, priority-encoded 3-bit ID presentation,
// and a valid/ack retire handshake. The presented ID is frozen until the consumer acks it.
module interrupt_controller_8 #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  interrupt_controller_8_if.slave  bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] pend, edge_det, clr, eligible;
  logic                 valid_q, valid_nxt;
  logic [2:0]           id_q, id_nxt, sel;

  // Per-line capture; clearing the line being acked loses to a fresh edge on it.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic prev_r, pend_r;

    assign edge_det[i] = LEVEL_MODE ? bus.irq_in[i] : (bus.irq_in[i] & ~prev_r);
    assign pend[i]     = pend_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_r <= 1'b0;
        pend_r <= 1'b0;
      end else begin
        prev_r <= bus.irq_in[i];
        pend_r <= (pend_r & ~clr[i]) | edge_det[i];
      end
    end
  end

  assign eligible = pend & ~bus.mask;

  // Ascending scan: the last hit is the highest eligible line.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (eligible[i]) sel = 3'(i);
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    id_nxt    = id_q;
    clr       = '0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|eligible) begin
          id_nxt    = sel;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        valid_nxt = 1'b1;
        if (bus.irq_ack) begin
          clr[id_q] = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      id_q    <= id_nxt;
    end
  end

  assign bus.irq_valid = valid_q;
  assign bus.irq_id    = id_q;
  assign bus.pending   = pend;
endmodule
